truth_table_sweeper: RTL and testbench

Sequencer that drives a 4-input combinational function under test (FUT) through all 16 input vectors. It holds each vector for a programmable settle time, samples the FUT output, and builds the measured 16-bit truth table. It compares that table with an expected table and reports pass, or the first failing index. It sits beside any `f(a,b,c,d)` implementation, so the same function can be checked in hardware rather than only by a hand-written stimulus sweep.

---
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | truth_table_sweeper                                                      |
// | Drives a 4-input FUT through all 16 vectors, samples its output, builds  |
// | the measured truth table and compares it with an expected table.         |
// | Optional: SWEEP_GRAY_EN selects Gray-order vector stepping.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [3:0]  fail_idx
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [7:0] c_last_cnt = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_step;
    logic [7:0]  r_cnt;
    logic [15:0] r_exp;

    logic [3:0]  w_vec;
    logic [3:0]  w_vec_next;
    logic        w_sample;
    logic [15:0] w_table_final;
    logic [15:0] w_diff;
    logic [3:0]  w_fail_idx;

    // Step-to-vector mapping; the table is always indexed by binary value.
    function automatic logic [3:0] f_vec(input logic [3:0] s);
`ifdef SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    assign w_vec      = f_vec(r_step);
    assign w_vec_next = f_vec(r_step + 4'd1);
    assign w_sample   = (r_cnt == c_last_cnt);

    // Table including the bit captured on this edge, so the verdict on the
    // final sample edge sees all 16 entries.
    always_comb begin
        w_table_final        = table_out;
        w_table_final[w_vec] = f_in;
        w_diff               = w_table_final ^ r_exp;
        w_fail_idx           = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_fail_idx = i[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_step    <= 4'd0;
            r_cnt     <= 8'd0;
            r_exp     <= 16'd0;
            {a, b, c, d} <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 16'd0;
            pass      <= 1'b0;
            fail_idx  <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    done <= 1'b0;
                    if (start) begin
                        r_exp        <= expected;
                        table_out    <= 16'd0;
                        pass         <= 1'b0;
                        fail_idx     <= 4'd0;
                        r_step       <= 4'd0;
                        r_cnt        <= 8'd0;
                        {a, b, c, d} <= f_vec(4'd0);
                        busy         <= 1'b1;
                        r_state      <= c_st_drive;
                    end
                end
                c_st_drive: begin
                    if (w_sample) begin
                        table_out[w_vec] <= f_in;
                        r_cnt            <= 8'd0;
                        r_step           <= r_step + 4'd1;
                        if (r_step == 4'd15) begin
                            {a, b, c, d} <= 4'd0;
                            done         <= 1'b1;
                            pass         <= (w_table_final == r_exp);
                            fail_idx     <= w_fail_idx;
                            r_state      <= c_st_done;
                        end else begin
                            {a, b, c, d} <= w_vec_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_st_done: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_truth_table_sweeper                                                   |
// | Directed bench: one sweeper with SETTLE_CYCLES=4, one with 1.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start1;
    logic [15:0] exp4, exp1;
    logic        f4, f1;
    logic        a4, b4, c4, d4, busy4, done4, pass4;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] tab4, tab1;
    logic [3:0]  fi4, fi1;
    int          mode;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // FUT models: mode 0 = parity, mode 1 = AND with vector 5 stuck at 1.
    assign f4 = (mode == 0) ? (a4 ^ b4 ^ c4 ^ d4)
                            : ((a4 & b4 & c4 & d4) | ({a4, b4, c4, d4} == 4'd5));
    assign f1 = d1;

    truth_table_sweeper #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4), .f_in(f4),
        .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4),
        .table_out(tab4), .pass(pass4), .fail_idx(fi4)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(tab1), .pass(pass1), .fail_idx(fi1)
    );

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    function automatic logic [3:0] vec(input int k);
        logic [3:0] s;
        s = 4'(k);
`ifdef SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from edge 1 of an accepted S=4 sweep until busy drops after done.
    task automatic sweep4(input int inj_edge, input bit inj_done,
                          output int done_edge, output int done_cnt,
                          output int busy_cnt, output int vec_errs);
        done_edge = -1;
        done_cnt  = 0;
        busy_cnt  = busy4 ? 1 : 0;
        vec_errs  = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == inj_edge) begin
                start4 = 1'b1;
                exp4   = 16'h0000;
            end else if (n == inj_edge + 1) begin
                start4 = 1'b0;
            end
            if (inj_done && done_edge >= 0 && n == done_edge + 1) start4 = 1'b0;
            if (busy4) busy_cnt++;
            if (n < 64) begin
                if ({a4, b4, c4, d4} !== vec(n / 4)) vec_errs++;
            end else if ({a4, b4, c4, d4} !== 4'd0) begin
                vec_errs++;
            end
            if (done4) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = n;
                    if (inj_done) begin
                        start4 = 1'b1;
                        exp4   = 16'h0000;
                    end
                end
            end
            if (done_edge >= 0 && !busy4) break;
        end
    endtask

    initial begin
        int de, dc, bc, ve;
        logic [15:0] partial;
        rst_n  = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        exp4   = 16'h0;
        exp1   = 16'h0;
        mode   = 0;
        tick();
        tick();
        `CHK("rst_vec", {a4, b4, c4, d4}, 4'd0)
        `CHK("rst_busy_done", {busy4, done4, pass4}, 3'b000)
        `CHK("rst_table", tab4, 16'h0000)
        `CHK("rst_fail_idx", fi4, 4'd0)
        rst_n = 1'b1;
        tick();

        // Parity FUT, S=4
        exp4 = 16'h6996; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        `CHK("t1_busy_e0", busy4, 1'b1)
        `CHK("t1_vec_e0", {a4, b4, c4, d4}, 4'd0)
        sweep4(-10, 1'b0, de, dc, bc, ve);
        `CHK("t1_done_edge", de, 64)
        `CHK("t1_done_cnt", dc, 1)
        `CHK("t1_busy_cycles", bc, 65)
        `CHK("t1_vec_seq_errs", ve, 0)
        `CHK("t1_table", tab4, 16'h6996)
        `CHK("t1_pass", pass4, 1'b1)
        `CHK("t1_fail_idx", fi4, 4'd0)
        tick();
        `CHK("t1_pass_held", pass4, 1'b1)

        // AND FUT with vector 5 stuck high
        mode = 1; exp4 = 16'h8000; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        sweep4(-10, 1'b0, de, dc, bc, ve);
        `CHK("t2_done_edge", de, 64)
        `CHK("t2_table", tab4, 16'h8020)
        `CHK("t2_pass", pass4, 1'b0)
        `CHK("t2_fail_idx", fi4, 4'd5)

        // S=1, FUT = d
        exp1 = 16'hAAAA; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        `CHK("t3_vec_e0", {a1, b1, c1, d1}, 4'd0)
        ve = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if ({a1, b1, c1, d1} !== vec(k) || done1 !== 1'b0) ve++;
        end
        `CHK("t3_vec_seq_errs", ve, 0)
        tick();
        `CHK("t3_done_e16", done1, 1'b1)
        `CHK("t3_table", tab1, 16'hAAAA)
        `CHK("t3_pass", pass1, 1'b1)
        `CHK("t3_fail_idx", fi1, 4'd0)
        tick();
        `CHK("t3_idle", {busy1, done1}, 2'b00)

        // Reset at cycle 20 of a sweep
        mode = 0; exp4 = 16'h6996; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (20) tick();
`ifdef SWEEP_GRAY_EN
        partial = 16'h0006;
`else
        partial = 16'h0016;
`endif
        `CHK("t4_partial_table", tab4, partial)
        rst_n = 1'b0;
        #1;
        `CHK("t4_rst_vec", {a4, b4, c4, d4}, 4'd0)
        `CHK("t4_rst_busy", busy4, 1'b0)
        `CHK("t4_rst_table", tab4, 16'h0000)
        tick();
        rst_n = 1'b1;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        sweep4(-10, 1'b0, de, dc, bc, ve);
        `CHK("t4_done_edge", de, 64)
        `CHK("t4_table", tab4, 16'h6996)
        `CHK("t4_pass", pass4, 1'b1)

        // Starts during DRIVE and in the DONE cycle are ignored
        exp4 = 16'h6996; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        sweep4(10, 1'b1, de, dc, bc, ve);
        start4 = 1'b0;
        `CHK("t5_done_cnt", dc, 1)
        `CHK("t5_done_edge", de, 64)
        `CHK("t5_table", tab4, 16'h6996)
        `CHK("t5_pass", pass4, 1'b1)
        `CHK("t5_fail_idx", fi4, 4'd0)
        tick();
        `CHK("t5_no_restart", {busy4, done4}, 2'b00)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

`undef CHK

endmodule
`default_nettype wire
